gba_cart_top: RTL and testbench
===============================

// Module: gba_cart_top
// PURPOSE
//  FPGA top for a GBA cartridge emulator. Bridges the asynchronous GBA cart bus to an
//  internal 8-bit SRAM (backup-save region, nCS2) plus a small control-register window.
//  The ROM region (nCS) is not served; a board heartbeat LED and a debug byte are exported.
// PARAMETERS
//  SRAM_AW    12        SRAM address bits (2^12 = 4 KiB); lower AD bits index RAM, RAM mirrors
//  BLINK_DIV  25000000  clock cycles per LED half-period
//  ID_BYTE    8'h47     read-only value at control address 0xF001
// PORTS
//  clock               in   1   system clock; all logic on rising edge
//  reset               in   1   asynchronous, active-high reset
//  io_host_gba_CLK     in   1   GBA cart clock; unused
//  io_host_gba_nWR     in   1   bus write strobe, active low, async
//  io_host_gba_nRD     in   1   bus read strobe, active low, async
//  io_host_gba_nCS     in   1   ROM chip select, active low; ignored
//  io_host_gba_nCS2    in   1   SRAM chip select, active low, async
//  io_host_gba_nREQ    out  1   interrupt request, active low; constant 1
//  io_host_gba_VDD     in   1   cart power good; 0 forces all outputs undriven
//  io_host_gba_AD_in   in   16  SRAM address (AD[15:0])
//  io_host_gba_AD_out  out  16  constant 16'h0000
//  io_host_gba_AD_oe   out  1   constant 0
//  io_host_gba_A_in    in   8   SRAM write data (A[23:16])
//  io_host_gba_A_out   out  8   SRAM read data
//  io_host_gba_A_oe    out  1   drive enable for A_out
//  io_board_gba_debug  out  8   contents of control register CTRL (0xF000)
//  io_board_blinky_led out  1   heartbeat LED
// BEHAVIOUR
//  - Reset: A_out=0, A_oe=0, CTRL=0, debug=0, LED=0, blink counter=0, synchronizers=1
//    (idle); RAM contents undefined (not cleared).
//  - nWR, nRD, nCS2 pass 2-flop synchronizers; AD_in/A_in sampled with same 2-flop delay.
//  - Address map (nCS2 region): 0xF000 CTRL r/w; 0xF001 ID r/o (writes ignored);
//    0xF002-0xFFFF read 0x00, writes ignored; 0x0000-0xEFFF -> RAM[addr[SRAM_AW-1:0]].
//  - Write: on synchronized nWR rising edge with synchronized nCS2=0, commit the A_in/AD_in
//    sampled the cycle before the edge. Exactly one write per strobe regardless of length.
//  - Read: while sync nCS2=0 and sync nRD=0 and VDD=1: A_oe=1, A_out=read data of current
//    address; valid no later than 4 clocks after raw nRD falls; tracks address changes.
//  - A_oe drops within 3 clocks of nRD or nCS2 rising; A_out holds last value afterwards.
//  - nWR and nRD both low: write ignored, read served.
//  - nCS2 high: strobes ignored, no RAM/CTRL change.
//  - VDD=0: A_oe=0, no writes commit; regs hold.
//  - Reset mid-access: outputs return to reset values immediately; pending write dropped.
//  - nCS, CLK unused; nREQ=1, AD_oe=0, AD_out=0 always.
// CONFIGURATION
//  BLINKY_EN defined: LED toggles every BLINK_DIV clocks (free-running counter, wraps).
//  BLINKY_EN undefined: no counter; LED = CTRL[0].
// TESTING
//  - nCS2=0, AD=0x0000, A_in=0xAA, nWR low 10 clk -> RAM[0]=0xAA; A_oe stays 0.
//  - Write 0x55 @0x0001; read @0x0000 then @0x0001 (nRD low 10 clk) -> A_out 0xAA, 0x55,
//    A_oe=1 only during nRD low (+<=3 clk).
//  - Write 0xDD @0xF000 -> debug=0xDD; read @0xF000 -> 0xDD; read @0x0000 still 0xAA.
//  - Read @0xF001 -> 0x47; write 0x00 @0xF001 then read -> still 0x47.
//  - Write 0x12 @0x1000 (mirror) -> read @0x0000 returns 0x12; nWR pulse with nCS2=1 -> no change.
//  - Assert reset during nRD low -> A_oe=0 same cycle, debug=0; nREQ=1, AD_oe=0 throughout.

Source files
------------

// File: rtl/gba_cart_top.sv
// GBA cartridge bridge: async cart bus (nCS2 region) to internal 8-bit SRAM plus control window.
// Optional macro BLINKY_EN: free-running heartbeat LED; otherwise the LED mirrors CTRL[0].
module gba_cart_top #(
  parameter int          SRAM_AW   = 12,
  parameter int          BLINK_DIV = 25000000,
  parameter logic [7:0]  ID_BYTE   = 8'h47
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_host_gba_CLK,
  input  logic        io_host_gba_nWR,
  input  logic        io_host_gba_nRD,
  input  logic        io_host_gba_nCS,
  input  logic        io_host_gba_nCS2,
  output logic        io_host_gba_nREQ,
  input  logic        io_host_gba_VDD,
  input  logic [15:0] io_host_gba_AD_in,
  output logic [15:0] io_host_gba_AD_out,
  output logic        io_host_gba_AD_oe,
  input  logic [7:0]  io_host_gba_A_in,
  output logic [7:0]  io_host_gba_A_out,
  output logic        io_host_gba_A_oe,
  output logic [7:0]  io_board_gba_debug,
  output logic        io_board_blinky_led
);

  logic [1:0]  r_nwr_s, r_nrd_s, r_ncs2_s;
  logic [15:0] r_ad_s1, r_ad_s2, r_wr_ad;
  logic [7:0]  r_din_s1, r_din_s2, r_wr_dat;
  logic        r_nwr_q, r_wr_blk;
  logic [7:0]  r_ctrl, r_a_out;
  logic        r_a_oe;
  logic [7:0]  r_mem [2**SRAM_AW];

  logic        w_nwr, w_nrd, w_ncs2, w_wr_go;
  logic [7:0]  w_rd_data;
  logic        w_unused;

  assign w_nwr  = r_nwr_s[1];
  assign w_nrd  = r_nrd_s[1];
  assign w_ncs2 = r_ncs2_s[1];
  assign w_unused = io_host_gba_CLK ^ io_host_gba_nCS;

  // One commit per strobe: rising edge of synced nWR; a read seen during the strobe blocks it.
  assign w_wr_go = w_nwr & ~r_nwr_q & ~w_ncs2 & io_host_gba_VDD & ~r_wr_blk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nwr_s  <= 2'b11;
      r_nrd_s  <= 2'b11;
      r_ncs2_s <= 2'b11;
      r_ad_s1  <= '0;
      r_ad_s2  <= '0;
      r_din_s1 <= '0;
      r_din_s2 <= '0;
      r_nwr_q  <= 1'b1;
      r_wr_blk <= 1'b0;
      r_wr_ad  <= '0;
      r_wr_dat <= '0;
      r_ctrl   <= '0;
      r_a_out  <= '0;
      r_a_oe   <= 1'b0;
    end else begin
      r_nwr_s  <= {r_nwr_s[0], io_host_gba_nWR};
      r_nrd_s  <= {r_nrd_s[0], io_host_gba_nRD};
      r_ncs2_s <= {r_ncs2_s[0], io_host_gba_nCS2};
      r_ad_s1  <= io_host_gba_AD_in;
      r_ad_s2  <= r_ad_s1;
      r_din_s1 <= io_host_gba_A_in;
      r_din_s2 <= r_din_s1;
      r_nwr_q  <= w_nwr;
      if (!w_nwr) begin
        r_wr_ad  <= r_ad_s2;
        r_wr_dat <= r_din_s2;
      end
      if (w_nwr)       r_wr_blk <= 1'b0;
      else if (!w_nrd) r_wr_blk <= 1'b1;
      if (w_wr_go && r_wr_ad == 16'hF000) r_ctrl <= r_wr_dat;
      r_a_oe <= ~w_ncs2 & ~w_nrd & io_host_gba_VDD;
      if (~w_ncs2 & ~w_nrd & io_host_gba_VDD) r_a_out <= w_rd_data;
    end
  end

  // RAM contents survive reset on purpose; only the bus-side state is cleared.
  always_ff @(posedge clock) begin
    if (w_wr_go && r_wr_ad[15:12] != 4'hF)
      r_mem[r_wr_ad[SRAM_AW-1:0]] <= r_wr_dat;
  end

  always_comb begin
    w_rd_data = 8'h00;
    if (r_ad_s2[15:12] != 4'hF)    w_rd_data = r_mem[r_ad_s2[SRAM_AW-1:0]];
    else if (r_ad_s2 == 16'hF000)  w_rd_data = r_ctrl;
    else if (r_ad_s2 == 16'hF001)  w_rd_data = ID_BYTE;
  end

  assign io_host_gba_nREQ   = 1'b1;
  assign io_host_gba_AD_out = 16'h0000;
  assign io_host_gba_AD_oe  = 1'b0;
  assign io_host_gba_A_out  = r_a_out;
  assign io_host_gba_A_oe   = r_a_oe & io_host_gba_VDD;
  assign io_board_gba_debug = r_ctrl;

`ifdef BLINKY_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [CW-1:0] r_blink_cnt;
  logic          r_led;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_led       <= 1'b0;
    end else if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_led       <= ~r_led;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end
  assign io_board_blinky_led = r_led;
`else
  assign io_board_blinky_led = r_ctrl[0];
`endif

endmodule

// File: tb/tb_gba_cart_top.sv
// Directed bench for gba_cart_top: bus writes/reads, control window, mirroring, reset mid-read.
module tb_gba_cart_top;
  logic        clock = 1'b0;
  logic        reset;
  logic        gclk_unused = 1'b0;
  logic        nwr, nrd, ncs, ncs2, vdd;
  logic [15:0] ad_in;
  logic [7:0]  a_in;
  logic        nreq, ad_oe, a_oe, led;
  logic [15:0] ad_out;
  logic [7:0]  a_out, dbg;
  int tests = 0;
  int fails = 0;

  gba_cart_top dut (
    .clock(clock), .reset(reset),
    .io_host_gba_CLK(gclk_unused), .io_host_gba_nWR(nwr), .io_host_gba_nRD(nrd),
    .io_host_gba_nCS(ncs), .io_host_gba_nCS2(ncs2), .io_host_gba_nREQ(nreq),
    .io_host_gba_VDD(vdd), .io_host_gba_AD_in(ad_in), .io_host_gba_AD_out(ad_out),
    .io_host_gba_AD_oe(ad_oe), .io_host_gba_A_in(a_in), .io_host_gba_A_out(a_out),
    .io_host_gba_A_oe(a_oe), .io_board_gba_debug(dbg), .io_board_blinky_led(led)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input logic cs_n);
    ad_in = addr; a_in = data; ncs2 = cs_n;
    clk(2);
    nwr = 1'b0;
    clk(10);
    chk("write_no_oe", {15'd0, a_oe}, 16'd0);
    nwr = 1'b1;
    clk(4);
    ncs2 = 1'b1;
    clk(2);
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    ad_in = addr; ncs2 = 1'b0; nrd = 1'b0;
    clk(4);
    chk({tag, "_oe"}, {15'd0, a_oe}, 16'd1);
    chk({tag, "_data"}, {8'd0, a_out}, {8'd0, exp});
    clk(6);
    nrd = 1'b1;
    clk(3);
    chk({tag, "_oe_drop"}, {15'd0, a_oe}, 16'd0);
    chk({tag, "_hold"}, {8'd0, a_out}, {8'd0, exp});
    chk({tag, "_nreq"}, {15'd0, nreq}, 16'd1);
    ncs2 = 1'b1;
    clk(2);
  endtask

  initial begin
    reset = 1'b1; nwr = 1'b1; nrd = 1'b1; ncs = 1'b1; ncs2 = 1'b1; vdd = 1'b1;
    ad_in = '0; a_in = '0;
    clk(3);
    chk("rst_a_oe", {15'd0, a_oe}, 16'd0);
    chk("rst_a_out", {8'd0, a_out}, 16'd0);
    chk("rst_debug", {8'd0, dbg}, 16'd0);
    chk("rst_led", {15'd0, led}, 16'd0);
    reset = 1'b0;
    clk(2);

    bus_write(16'h0000, 8'hAA, 1'b0);
    bus_write(16'h0001, 8'h55, 1'b0);
    bus_read("rd0", 16'h0000, 8'hAA);
    bus_read("rd1", 16'h0001, 8'h55);

    bus_write(16'hF000, 8'hDD, 1'b0);
    chk("ctrl_debug", {8'd0, dbg}, 16'h00DD);
    chk("ctrl_led", {15'd0, led}, 16'd1);
    bus_read("rd_ctrl", 16'hF000, 8'hDD);
    bus_read("rd0_again", 16'h0000, 8'hAA);

    bus_read("rd_id", 16'hF001, 8'h47);
    bus_write(16'hF001, 8'h00, 1'b0);
    bus_read("rd_id_ro", 16'hF001, 8'h47);
    bus_read("rd_hole", 16'hF002, 8'h00);

    bus_write(16'h1000, 8'h12, 1'b0);
    bus_read("rd_mirror", 16'h0000, 8'h12);
    bus_write(16'h0000, 8'h99, 1'b1);
    bus_write(16'hF000, 8'h01, 1'b1);
    chk("cs_hi_ctrl", {8'd0, dbg}, 16'h00DD);
    bus_read("rd_cs_hi", 16'h0000, 8'h12);

    // Write and read strobes overlap: read served, write dropped.
    ad_in = 16'h0001; a_in = 8'h77; ncs2 = 1'b0; nrd = 1'b0; nwr = 1'b0;
    clk(6);
    chk("both_low_data", {8'd0, a_out}, 16'h0055);
    nrd = 1'b1; nwr = 1'b1;
    clk(4);
    ncs2 = 1'b1;
    clk(2);
    bus_read("rd_both_low", 16'h0001, 8'h55);

    // Power removed: no read drive, no write commit.
    vdd = 1'b0;
    bus_write(16'h0001, 8'h33, 1'b0);
    ad_in = 16'h0001; ncs2 = 1'b0; nrd = 1'b0;
    clk(5);
    chk("vdd0_oe", {15'd0, a_oe}, 16'd0);
    nrd = 1'b1; ncs2 = 1'b1; vdd = 1'b1;
    clk(3);
    bus_read("rd_vdd0", 16'h0001, 8'h55);

    // Reset asserted mid-read.
    ad_in = 16'h0000; ncs2 = 1'b0; nrd = 1'b0;
    clk(5);
    chk("pre_rst_oe", {15'd0, a_oe}, 16'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_oe", {15'd0, a_oe}, 16'd0);
    chk("mid_rst_debug", {8'd0, dbg}, 16'd0);
    chk("mid_rst_out", {8'd0, a_out}, 16'd0);
    chk("mid_rst_nreq", {15'd0, nreq}, 16'd1);
    chk("mid_rst_ad_oe", {15'd0, ad_oe}, 16'd0);
    chk("mid_rst_ad_out", ad_out, 16'h0000);
    clk(2);
    nrd = 1'b1; ncs2 = 1'b1;
    reset = 1'b0;
    clk(3);
    chk("end_ad_oe", {15'd0, ad_oe}, 16'd0);
    chk("end_nreq", {15'd0, nreq}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
